line_buffer_pingpong: RTL and testbench
=======================================

Name: line_buffer_pingpong

Overview:
Parametrised dual-bank scanline buffer between VRAM (single-port SRAM on the fast clock wclk) and the pixel pipeline (pclk).
- Fills one bank with the next scanline while the other bank is streamed to the DAC.
- Bank swaps happen on line boundaries.
- Handles VRAM bus contention with a restart gap, wraps the VRAM line pointer at a programmable limit, and flags overruns.
- All pclk-to-wclk events use toggle synchronisers.

Parameters:
DATA_W, 16, pixel/VRAM word width
LINE_WORDS, 640, words per scanline held in each bank
BANK_AW, 10, bank address width; LINE_WORDS must be <= 2^BANK_AW
VADDR_W, 20, VRAM address width
ADDR_STEP, 2, VRAM address increment per word
RESTART_GAP, 2, idle wclk cycles after bus_busy deasserts before issuing again

Ports:
wclk  in  1  fast VRAM-side clock
RESET  in  1  synchronous, active-low reset, wclk domain
pclk  in  1  pixel clock
vram_data  in  DATA_W  SRAM read data
vram_addr  out  VADDR_W  SRAM address
vram_rd_n  out  1  SRAM read strobe, active low
vram_ce_n  out  1  SRAM chip enable, active low
bus_busy  in  1  1 = another master owns the VRAM bus (wclk domain)
base_addr  in  VADDR_W  VRAM address of line 0; quasi-static
max_addr  in  VADDR_W  line pointer wraps to base_addr when the next line start >= max_addr
frame_start  in  1  pclk pulse in vblank; restarts at line 0
line_end  in  1  pclk pulse per hsync; swaps banks
de  in  1  pclk active-video enable
pix_out  out  DATA_W  pixel word (pclk)
pix_valid  out  1  pix_out carries buffer data (pclk)
fill_done  out  1  wclk; current write bank holds a complete line
underrun  out  1  wclk sticky; a swap arrived before the fill completed
bank_sel  out  1  wclk; bank currently being written

Behaviour:
Reset
- RESET is the reset for the wclk domain. The pclk domain uses a 2-FF synchronised copy, so pclk registers are reset within 2 pclk edges.
- Reset values: vram_rd_n=1, vram_ce_n=1, vram_addr=0, pix_out=0, pix_valid=0, fill_done=0, underrun=0, bank_sel=0.
- Internal: FSM=IDLE, line pointer lp=base_addr, pclk rd_bank=1.

Crossing
- frame_start and line_end each flip a pclk toggle register.
- Each toggle is 2-FF synchronised into wclk; an edge detector produces one wclk event per pulse.
- If both pulse in the same pclk cycle, only frame_start is toggled. If both wclk events land in the same cycle, frame wins.

Pixel side (pclk)
- line_end: rd_bank <= ~rd_bank.
- frame_start: rd_bank <= 1.
- While de=1: raddr increments. Bank read is registered; pix_out = bank[rd_bank][raddr] one pclk after de rises, and pix_valid=1 while the delayed de=1.
- raddr saturates at LINE_WORDS-1. Past saturation: pix_out=0, pix_valid=0.
- de=0: raddr=0, and from the next edge pix_out=0, pix_valid=0.

Fill FSM (wclk): IDLE, ISSUE, STALL, DONE
- frame event: lp<=base_addr; bank_sel<=0; underrun<=0; ia=0, wi=0; go to ISSUE.
- line event: bank_sel<=~bank_sel. If state != DONE, set underrun<=1. Then advance lp and restart ISSUE with ia=0, wi=0.
- Line pointer advance: nxt = lp + LINE_WORDS*ADDR_STEP (VADDR_W-bit arithmetic, carry dropped). lp <= (nxt >= max_addr) ? base_addr : nxt.
- ISSUE with bus_busy=0 and ia<LINE_WORDS:
  - vram_addr = lp + ia*ADDR_STEP; rd_n=ce_n=0; ia++.
  - A word issued in cycle N is written to bank[bank_sel][wi] at edge N+1 regardless of bus_busy at N+1; wi++.
- ISSUE with bus_busy=1: rd_n=ce_n=1, no issue; go to STALL.
- STALL: hold until bus_busy=0, then count RESTART_GAP further cycles with rd_n=ce_n=1, then return to ISSUE.
  - bus_busy reasserted during the gap restarts the gap count.
  - No word may be skipped or written twice.
- When wi reaches LINE_WORDS: DONE; fill_done=1; rd_n=ce_n=1. fill_done clears on any frame or line event.
- vram_addr holds its last value while not issuing.
- RESET low mid-fill: everything returns to reset values on the next wclk edge; any in-flight capture is discarded.

Test Plan:
1. LINE_WORDS=8, base=0, vram_data=addr/2, frame_start then one line_end, then de for 8 pclk -> vram_addr 0,2,…,14 with rd_n low for 8 cycles, fill_done=1; pix_out=0..7 starting one pclk after de, pix_valid high for 8 cycles.
2. bus_busy high for 5 cycles after the 3rd issue, RESTART_GAP=2 -> rd_n high for 7 cycles; addresses resume at 6; bank holds 0..7 exactly once.
3. base=0, max_addr=0x20, LINE_WORDS=8 -> line fills start at 0x00, 0x10, 0x00 (wrap), 0x10.
4. bus_busy held high until line_end arrives -> underrun=1, fill restarts at the next line address with bank_sel toggled; the following frame_start clears underrun.
5. RESET low at wi=4 -> next wclk: rd_n=ce_n=1, vram_addr=0, fill_done=0; pix_out=0 within 2 pclk.
6. frame_start and line_end in the same pclk cycle -> treated as a frame only: lp=base, bank_sel=0, no underrun.

Source files
------------

// File: rtl/line_buffer_pingpong_if.sv
// VRAM bus bundle for the ping-pong scanline buffer.
//   vram_data : SRAM read data            (slave -> master)
//   bus_busy  : another master owns bus   (slave -> master)
//   vram_addr : SRAM word address         (master -> slave)
//   vram_rd_n : SRAM read strobe, low     (master -> slave)
//   vram_ce_n : SRAM chip enable, low     (master -> slave)
interface line_buffer_pingpong_if #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned VADDR_W = 20
);
  logic [DATA_W-1:0]  vram_data;
  logic [VADDR_W-1:0] vram_addr;
  logic               vram_rd_n;
  logic               vram_ce_n;
  logic               bus_busy;

  modport master (
    input  vram_data,
    input  bus_busy,
    output vram_addr,
    output vram_rd_n,
    output vram_ce_n
  );

  modport slave (
    output vram_data,
    output bus_busy,
    input  vram_addr,
    input  vram_rd_n,
    input  vram_ce_n
  );
endinterface

// File: rtl/line_buffer_pingpong.sv
// Dual-bank scanline buffer. The wclk side fills one bank from VRAM while the pclk side
// streams the other bank to the DAC; banks swap on line_end.
//   wclk, RESET   : VRAM-side clock, synchronous active-low reset
//   pclk          : pixel clock
//   vram_bus      : VRAM master port (address, strobes, read data, bus_busy)
//   i_base_addr   : VRAM address of line 0
//   i_max_addr    : line pointer wraps to base when the next line start >= this
//   i_frame_start : pclk pulse, restart at line 0
//   i_line_end    : pclk pulse, swap banks
//   i_de          : pclk active-video enable
//   o_pix_out     : pixel word (pclk)
//   o_pix_valid   : o_pix_out carries buffer data (pclk)
//   o_fill_done   : current write bank holds a complete line (wclk)
//   o_underrun    : sticky, a swap arrived before the fill completed (wclk)
//   o_bank_sel    : bank currently being written (wclk)
module line_buffer_pingpong #(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned LINE_WORDS  = 640,
  parameter int unsigned BANK_AW     = 10,
  parameter int unsigned VADDR_W     = 20,
  parameter int unsigned ADDR_STEP   = 2,
  parameter int unsigned RESTART_GAP = 2
) (
  input  logic                   wclk,
  input  logic                   RESET,
  input  logic                   pclk,
  line_buffer_pingpong_if.master vram_bus,
  input  logic [VADDR_W-1:0]     i_base_addr,
  input  logic [VADDR_W-1:0]     i_max_addr,
  input  logic                   i_frame_start,
  input  logic                   i_line_end,
  input  logic                   i_de,
  output logic [DATA_W-1:0]      o_pix_out,
  output logic                   o_pix_valid,
  output logic                   o_fill_done,
  output logic                   o_underrun,
  output logic                   o_bank_sel
);

  localparam int unsigned CntW = BANK_AW + 1;
  localparam int unsigned GapW = (RESTART_GAP < 1) ? 1 : $clog2(RESTART_GAP + 1);
  localparam logic [CntW-1:0]    LineCnt    = CntW'(LINE_WORDS);
  localparam logic [CntW-1:0]    LastIdx    = CntW'(LINE_WORDS - 1);
  localparam logic [BANK_AW-1:0] LastRaddr  = BANK_AW'(LINE_WORDS - 1);
  localparam logic [GapW-1:0]    GapEnd     = GapW'(RESTART_GAP);
  localparam logic [VADDR_W-1:0] Step       = VADDR_W'(ADDR_STEP);
  localparam logic [VADDR_W-1:0] LineStride = VADDR_W'(LINE_WORDS * ADDR_STEP);

  typedef enum logic [1:0] {StIdle, StIssue, StStall, StDone} state_e;

  // Both banks in one array, indexed {bank, word}.
  logic [DATA_W-1:0] r_mem [0:2**(BANK_AW+1)-1];

  // ---------------------------------------------------------------- pclk domain
  logic               r_prst_s1, r_prst_s2;
  logic               w_prst_n;
  logic               r_fs_tgl, r_le_tgl;
  logic               r_rd_bank;
  logic [BANK_AW-1:0] r_raddr;
  logic               r_past;
  logic [DATA_W-1:0]  r_pix_out;
  logic               r_pix_valid;

  always_ff @(posedge pclk) begin
    r_prst_s1 <= RESET;
    r_prst_s2 <= r_prst_s1;
  end

  // Reset asserts after one pclk edge; release waits for both stages.
  assign w_prst_n = r_prst_s1 & r_prst_s2;

  always_ff @(posedge pclk) begin
    if (!w_prst_n) begin
      r_fs_tgl    <= 1'b0;
      r_le_tgl    <= 1'b0;
      r_rd_bank   <= 1'b1;
      r_raddr     <= '0;
      r_past      <= 1'b0;
      r_pix_out   <= '0;
      r_pix_valid <= 1'b0;
    end else begin
      // A coincident line_end is absorbed by the frame restart.
      if (i_frame_start) begin
        r_fs_tgl  <= ~r_fs_tgl;
        r_rd_bank <= 1'b1;
      end else if (i_line_end) begin
        r_le_tgl  <= ~r_le_tgl;
        r_rd_bank <= ~r_rd_bank;
      end

      if (i_de && !r_past) begin
        r_pix_out   <= r_mem[{r_rd_bank, r_raddr}];
        r_pix_valid <= 1'b1;
        if (r_raddr == LastRaddr) r_past  <= 1'b1;
        else                      r_raddr <= r_raddr + 1'b1;
      end else begin
        r_pix_out   <= '0;
        r_pix_valid <= 1'b0;
        if (!i_de) begin
          r_raddr <= '0;
          r_past  <= 1'b0;
        end
      end
    end
  end

  assign o_pix_out   = r_pix_out;
  assign o_pix_valid = r_pix_valid;

  // ---------------------------------------------------------------- wclk domain
  logic [2:0]         r_fs_sync, r_le_sync;
  logic               w_frame_ev, w_line_ev;
  state_e             r_state;
  logic [VADDR_W-1:0] r_lp;
  logic [CntW-1:0]    r_ia, r_wi;
  logic [GapW-1:0]    r_gap;
  logic               r_bank_sel, r_fill_done, r_underrun;
  logic [VADDR_W-1:0] r_addr;
  logic               r_strobe_n;
  logic [VADDR_W-1:0] w_issue_addr, w_lp_nxt, w_lp_adv;
  logic               w_more, w_capture, w_last_cap;

  always_ff @(posedge wclk) begin
    if (!RESET) begin
      r_fs_sync <= '0;
      r_le_sync <= '0;
    end else begin
      r_fs_sync <= {r_fs_sync[1:0], r_fs_tgl};
      r_le_sync <= {r_le_sync[1:0], r_le_tgl};
    end
  end

  assign w_frame_ev = r_fs_sync[2] ^ r_fs_sync[1];
  assign w_line_ev  = (r_le_sync[2] ^ r_le_sync[1]) & ~w_frame_ev;

  always_comb begin
    w_issue_addr = r_lp + VADDR_W'(r_ia) * Step;
    w_lp_nxt     = r_lp + LineStride;
    w_lp_adv     = (w_lp_nxt >= i_max_addr) ? i_base_addr : w_lp_nxt;
    w_more       = (r_ia < LineCnt);
    // The strobe register being low means a word was on the bus this cycle.
    w_capture    = ~r_strobe_n;
    w_last_cap   = w_capture && (r_wi == LastIdx);
  end

  // Capture in the event cycle is dropped: its word belongs to the abandoned line.
  always_ff @(posedge wclk) begin
    if (RESET && w_capture && !w_frame_ev && !w_line_ev) begin
      r_mem[{r_bank_sel, r_wi[BANK_AW-1:0]}] <= vram_bus.vram_data;
    end
  end

  always_ff @(posedge wclk) begin
    if (!RESET) begin
      r_state     <= StIdle;
      r_lp        <= i_base_addr;
      r_ia        <= '0;
      r_wi        <= '0;
      r_gap       <= '0;
      r_bank_sel  <= 1'b0;
      r_fill_done <= 1'b0;
      r_underrun  <= 1'b0;
      r_addr      <= '0;
      r_strobe_n  <= 1'b1;
    end else if (w_frame_ev || w_line_ev) begin
      if (w_frame_ev) begin
        r_lp       <= i_base_addr;
        r_bank_sel <= 1'b0;
        r_underrun <= 1'b0;
      end else begin
        r_lp       <= w_lp_adv;
        r_bank_sel <= ~r_bank_sel;
        if (r_state != StDone) r_underrun <= 1'b1;
      end
      r_state     <= StIssue;
      r_ia        <= '0;
      r_wi        <= '0;
      r_gap       <= '0;
      r_fill_done <= 1'b0;
      r_strobe_n  <= 1'b1;
    end else begin
      r_strobe_n <= 1'b1;
      if (w_capture) r_wi <= r_wi + 1'b1;

      unique case (r_state)
        StIdle, StDone: begin
        end
        StIssue: begin
          if (vram_bus.bus_busy) begin
            r_state <= StStall;
            r_gap   <= '0;
          end else if (w_more) begin
            r_addr     <= w_issue_addr;
            r_strobe_n <= 1'b0;
            r_ia       <= r_ia + 1'b1;
          end
        end
        StStall: begin
          if (vram_bus.bus_busy) begin
            r_gap <= '0;
          end else if (r_gap == GapEnd) begin
            // Gap complete: resume issuing in this same cycle.
            r_state <= StIssue;
            if (w_more) begin
              r_addr     <= w_issue_addr;
              r_strobe_n <= 1'b0;
              r_ia       <= r_ia + 1'b1;
            end
          end else begin
            r_gap <= r_gap + 1'b1;
          end
        end
      endcase

      if (w_last_cap) begin
        r_state     <= StDone;
        r_fill_done <= 1'b1;
        r_strobe_n  <= 1'b1;
      end
    end
  end

  assign vram_bus.vram_addr = r_addr;
  assign vram_bus.vram_rd_n = r_strobe_n;
  assign vram_bus.vram_ce_n = r_strobe_n;
  assign o_fill_done        = r_fill_done;
  assign o_underrun         = r_underrun;
  assign o_bank_sel         = r_bank_sel;

endmodule

// File: tb/tb_line_buffer_pingpong.sv
// Scoreboard bench for line_buffer_pingpong with LINE_WORDS=8: expected VRAM addresses and
// pixel words are queued by the stimulus and popped by independent monitors.
module tb_line_buffer_pingpong;

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 20;

  logic          wclk = 1'b0;
  logic          pclk = 1'b0;
  logic          RESET;
  logic [AW-1:0] base_addr = '0;
  logic [AW-1:0] max_addr  = 20'h20;
  logic          frame_start, line_end, de;
  logic [DW-1:0] pix_out;
  logic          pix_valid, fill_done, underrun, bank_sel;

  always #5  wclk = ~wclk;
  always #13 pclk = ~pclk;

  line_buffer_pingpong_if #(.DATA_W(DW), .VADDR_W(AW)) vram_bus ();

  // VRAM model: each word holds its address divided by two.
  assign vram_bus.vram_data = DW'(vram_bus.vram_addr >> 1);

  line_buffer_pingpong #(
    .DATA_W(DW), .LINE_WORDS(8), .BANK_AW(3), .VADDR_W(AW), .ADDR_STEP(2), .RESTART_GAP(2)
  ) dut (
    .wclk(wclk), .RESET(RESET), .pclk(pclk), .vram_bus(vram_bus),
    .i_base_addr(base_addr), .i_max_addr(max_addr),
    .i_frame_start(frame_start), .i_line_end(line_end), .i_de(de),
    .o_pix_out(pix_out), .o_pix_valid(pix_valid),
    .o_fill_done(fill_done), .o_underrun(underrun), .o_bank_sel(bank_sel)
  );

  int            n_checks = 0;
  int            n_pass   = 0;
  int            n_issue  = 0;
  int            n_pix    = 0;
  logic [AW-1:0] q_addr[$];
  logic [DW-1:0] q_pix[$];

  // Reference model of the line pointer and bank bookkeeping.
  logic [AW-1:0] m_lp;
  logic          m_wbank, m_rbank;
  logic [AW-1:0] m_line [2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Issue monitor.
  always @(negedge wclk) begin
    if (vram_bus.vram_rd_n === 1'b0) begin
      n_issue++;
      if (q_addr.size() == 0) begin
        n_checks++;
        $display("FAIL issue_unexpected: got addr 0x%0h, expected no issue", vram_bus.vram_addr);
      end else begin
        check("issue_addr", {vram_bus.vram_ce_n, vram_bus.vram_addr}, {1'b0, q_addr.pop_front()});
      end
    end
  end

  // Pixel monitor.
  always @(negedge pclk) begin
    if (pix_valid === 1'b1) begin
      n_pix++;
      if (q_pix.size() == 0) begin
        n_checks++;
        $display("FAIL pix_unexpected: got 0x%0h, expected no valid pixel", pix_out);
      end else begin
        check("pix_data", pix_out, q_pix.pop_front());
      end
    end
  end

  function automatic logic [AW-1:0] next_lp(input logic [AW-1:0] lp);
    logic [AW-1:0] n;
    n = lp + 20'd16;
    return (n >= max_addr) ? base_addr : n;
  endfunction

  task automatic push_line(input logic [AW-1:0] lp);
    for (int i = 0; i < 8; i++) q_addr.push_back(lp + AW'(2 * i));
  endtask

  task automatic pulse(input logic fs, input logic le);
    @(posedge pclk); #1;
    frame_start = fs;
    line_end    = le;
    @(posedge pclk); #1;
    frame_start = 1'b0;
    line_end    = 1'b0;
    repeat (8) @(posedge wclk);
  endtask

  task automatic do_frame();
    m_lp = base_addr; m_wbank = 1'b0; m_rbank = 1'b1;
    push_line(m_lp);
    pulse(1'b1, 1'b0);
  endtask

  task automatic do_line(input bit issues);
    m_lp = next_lp(m_lp); m_wbank = ~m_wbank; m_rbank = ~m_rbank;
    if (issues) push_line(m_lp);
    pulse(1'b0, 1'b1);
  endtask

  task automatic wait_fill(input string name);
    for (int k = 0; k < 200; k++) begin
      @(negedge wclk);
      if (fill_done === 1'b1) break;
    end
    check(name, fill_done, 1);
    m_line[m_wbank] = m_lp;
  endtask

  // de held for 10 pclk: 8 valid words, then saturation, then idle.
  task automatic read_line(input string name);
    int            v0;
    logic [DW-1:0] d0;
    v0 = n_pix;
    d0 = DW'(m_line[m_rbank] >> 1);
    for (int i = 0; i < 8; i++) q_pix.push_back(d0 + DW'(i));
    @(posedge pclk); #1 de = 1'b1;
    @(posedge pclk);
    @(negedge pclk);
    check({name, "_first_valid"}, pix_valid, 1);
    repeat (9) @(posedge pclk);
    #1 de = 1'b0;
    repeat (2) @(posedge pclk);
    @(negedge pclk);
    check({name, "_nvalid"}, n_pix - v0, 8);
    check({name, "_idle"}, {pix_valid, pix_out}, 0);
  endtask

  // Raise bus_busy across the edge ending the 3rd issue, for 5 sampled edges.
  task automatic busy_inject(output int hi);
    int seen;
    seen = 0;
    hi   = 0;
    for (int k = 0; k < 300 && seen < 3; k++) begin
      @(negedge wclk);
      if (vram_bus.vram_rd_n === 1'b0) seen++;
    end
    check("t2_issue_seen", seen, 3);
    if (seen != 3) return;
    vram_bus.bus_busy = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(posedge wclk); #1;
      if (k == 4) vram_bus.bus_busy = 1'b0;
      @(negedge wclk);
      if (vram_bus.vram_rd_n === 1'b1) hi++;
      else break;
    end
  endtask

  // Drop RESET while the 5th word is on the bus (four words already written).
  task automatic reset_mid_fill();
    int seen;
    seen = 0;
    for (int k = 0; k < 300 && seen < 5; k++) begin
      @(negedge wclk);
      if (vram_bus.vram_rd_n === 1'b0) seen++;
    end
    check("t5_issue_seen", seen, 5);
    RESET = 1'b0;
    @(negedge wclk);
    check("t5_rd_n", vram_bus.vram_rd_n, 1);
    check("t5_ce_n", vram_bus.vram_ce_n, 1);
    check("t5_addr", vram_bus.vram_addr, 0);
    check("t5_fill_done", fill_done, 0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base0, hi;
    RESET = 1'b0; frame_start = 1'b0; line_end = 1'b0; de = 1'b0;
    vram_bus.bus_busy = 1'b0;
    m_lp = '0; m_wbank = 1'b0; m_rbank = 1'b1;
    m_line[0] = '0; m_line[1] = '0;

    repeat (12) @(posedge wclk);
    @(negedge wclk);
    check("rst_rd_n", vram_bus.vram_rd_n, 1);
    check("rst_ce_n", vram_bus.vram_ce_n, 1);
    check("rst_addr", vram_bus.vram_addr, 0);
    check("rst_fill_done", fill_done, 0);
    check("rst_underrun", underrun, 0);
    check("rst_bank_sel", bank_sel, 0);
    check("rst_pix", {pix_valid, pix_out}, 0);
    @(posedge wclk); #1 RESET = 1'b1;
    repeat (4) @(posedge pclk);
    @(negedge wclk);
    check("idle_rd_n", vram_bus.vram_rd_n, 1);

    // Basic fill, swap and read-out.
    base0 = n_issue;
    do_frame();
    wait_fill("t1_fill");
    check("t1_nissue", n_issue - base0, 8);
    check("t1_bank_sel", bank_sel, m_wbank);
    check("t1_underrun", underrun, 0);
    do_line(1'b1);
    wait_fill("t1_fill2");
    check("t1_bank_sel2", bank_sel, m_wbank);
    check("t1_underrun2", underrun, 0);
    read_line("t1_read");

    // Line pointer wrap: 0x10 -> 0x00 -> 0x10.
    do_line(1'b1);
    wait_fill("t3_fill_wrap");
    read_line("t3_read_a");
    do_line(1'b1);
    wait_fill("t3_fill_b");
    read_line("t3_read_b");

    // Bus contention with restart gap.
    m_lp = base_addr; m_wbank = 1'b0; m_rbank = 1'b1;
    push_line(m_lp);
    fork
      pulse(1'b1, 1'b0);
      busy_inject(hi);
    join
    check("t2_rd_n_high_run", hi, 7);
    wait_fill("t2_fill");
    do_line(1'b1);
    wait_fill("t2_fill2");
    read_line("t2_read");

    // Underrun: bus held busy across a swap.
    vram_bus.bus_busy = 1'b1;
    do_line(1'b0);
    check("t4_no_underrun", underrun, 0);
    do_line(1'b0);
    check("t4_underrun", underrun, 1);
    check("t4_bank_sel", bank_sel, m_wbank);
    push_line(m_lp);
    @(posedge wclk); #1 vram_bus.bus_busy = 1'b0;
    wait_fill("t4_refill");
    check("t4_sticky", underrun, 1);
    do_frame();
    wait_fill("t4_frame_fill");
    check("t4_cleared", underrun, 0);
    check("t4_bank_sel0", bank_sel, 0);

    // Coincident frame_start and line_end during a stalled fill.
    vram_bus.bus_busy = 1'b1;
    do_line(1'b0);
    check("t6_pre_bank", bank_sel, 1);
    m_lp = base_addr; m_wbank = 1'b0; m_rbank = 1'b1;
    pulse(1'b1, 1'b1);
    check("t6_bank_sel", bank_sel, 0);
    check("t6_underrun", underrun, 0);
    push_line(base_addr);
    @(posedge wclk); #1 vram_bus.bus_busy = 1'b0;
    wait_fill("t6_fill");
    do_line(1'b1);
    wait_fill("t6_fill2");
    read_line("t6_read");

    // Reset in the middle of a fill.
    m_lp = base_addr; m_wbank = 1'b0; m_rbank = 1'b1;
    push_line(m_lp);
    fork
      pulse(1'b1, 1'b0);
      reset_mid_fill();
    join
    q_addr.delete();
    repeat (2) @(posedge pclk);
    @(negedge pclk);
    check("t5_pix", {pix_valid, pix_out}, 0);
    @(posedge wclk); #1 RESET = 1'b1;
    repeat (4) @(posedge pclk);
    @(negedge wclk);
    check("t5_idle_rd_n", vram_bus.vram_rd_n, 1);
    check("t5_idle_bank", bank_sel, 0);
    do_frame();
    wait_fill("t5_post_fill");
    do_line(1'b1);
    wait_fill("t5_post_fill2");
    read_line("t5_post_read");

    repeat (20) @(posedge wclk);
    check("addr_queue_empty", q_addr.size(), 0);
    check("pix_queue_empty", q_pix.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
